// File: rtl/uart_xcvr.sv
// Full-duplex UART: TX and RX engines with configurable data bits, parity and stop bits.
// Latency: TX line drops one clock after i_Tx_DV is sampled; RX pulses o_Rx_DV one clock after the last stop sample.
// Backpressure: none; i_Tx_DV is only honoured while TX is idle, RX never stalls.
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Parity_Err,
  output logic                 o_Rx_Frame_Err,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STP = IW'(STOP_BITS - 1);
  localparam logic PAR_ON  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (tx_state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          tx_cnt      <= '0;
          if (i_Tx_DV) begin
            tx_state    <= S_START;
            tx_shift    <= i_Tx_Byte;
            tx_par      <= (^i_Tx_Byte) ^ PAR_ODD;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
          end
        end
        S_START: begin
          if (tx_cnt != BIT_END) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt      <= '0;
            tx_idx      <= '0;
            o_Tx_Serial <= tx_shift[0];
            tx_shift    <= tx_shift >> 1;
            tx_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_cnt != BIT_END) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt <= '0;
            if (tx_idx != LAST_BIT) begin
              tx_idx      <= tx_idx + 1'b1;
              o_Tx_Serial <= tx_shift[0];
              tx_shift    <= tx_shift >> 1;
            end else if (PAR_ON) begin
              tx_state    <= S_PARITY;
              o_Tx_Serial <= tx_par;
            end else begin
              tx_state    <= S_STOP;
              o_Tx_Serial <= 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tx_cnt != BIT_END) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt      <= '0;
            tx_state    <= S_STOP;
            o_Tx_Serial <= 1'b1;
          end
        end
        S_STOP: begin
          // all stop bits are timed as one long interval
          if (tx_cnt != STOP_END) tx_cnt <= tx_cnt + 1'b1;
          else begin
            tx_cnt      <= '0;
            tx_state    <= S_IDLE;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;
  logic                 rx_ferr;
  logic                 rx_tick;
  logic                 ferr_now;

  assign rx_s     = rx_sync[1];
  assign rx_tick  = (rx_cnt == BIT_END);
  // with one stop bit the framing verdict comes from the sample being taken now
  assign ferr_now = (rx_idx == '0) ? ~rx_s : rx_ferr;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_sync         <= 2'b11;
      rx_state        <= S_IDLE;
      rx_cnt          <= '0;
      rx_idx          <= '0;
      rx_shift        <= '0;
      rx_par          <= 1'b0;
      rx_ferr         <= 1'b0;
      o_Rx_DV         <= 1'b0;
      o_Rx_Byte       <= '0;
      o_Rx_Parity_Err <= 1'b0;
      o_Rx_Frame_Err  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], i_Rx_Serial};
      o_Rx_DV <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt != MID) rx_cnt <= rx_cnt + 1'b1;
          else begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (!rx_tick) rx_cnt <= rx_cnt + 1'b1;
          else begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_idx != LAST_BIT) rx_idx <= rx_idx + 1'b1;
            else begin
              rx_idx   <= '0;
              rx_state <= PAR_ON ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (!rx_tick) rx_cnt <= rx_cnt + 1'b1;
          else begin
            rx_cnt   <= '0;
            rx_par   <= rx_s;
            rx_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (!rx_tick) rx_cnt <= rx_cnt + 1'b1;
          else begin
            rx_cnt <= '0;
            if (rx_idx == '0) rx_ferr <= ~rx_s;
            if (rx_idx != LAST_STP) rx_idx <= rx_idx + 1'b1;
            else begin
              rx_idx          <= '0;
              o_Rx_DV         <= 1'b1;
              o_Rx_Byte       <= rx_shift;
              o_Rx_Parity_Err <= PAR_ON && (rx_par != ((^rx_shift) ^ PAR_ODD));
              o_Rx_Frame_Err  <= ferr_now;
              // a break keeps the line low; re-arm only once it returns high
              rx_state        <= ferr_now ? S_WAIT : S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (rx_s) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: an 8E1 instance (loopback or driven RX) and a 7O2 instance in loopback.
module tb_uart_xcvr;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8E1 instance
  logic       a_loop = 1'b0;
  logic       a_rx_drv = 1'b1;
  logic       a_rx;
  logic       a_tx_dv = 1'b0;
  logic [7:0] a_tx_byte = 8'h00;
  logic       a_rx_dv, a_pe, a_fe, a_tx_active, a_tx_ser, a_tx_done;
  logic [7:0] a_rx_byte;
  assign a_rx = a_loop ? a_tx_ser : a_rx_drv;

  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(a_rx),
    .o_Rx_DV(a_rx_dv), .o_Rx_Byte(a_rx_byte), .o_Rx_Parity_Err(a_pe), .o_Rx_Frame_Err(a_fe),
    .i_Tx_DV(a_tx_dv), .i_Tx_Byte(a_tx_byte),
    .o_Tx_Active(a_tx_active), .o_Tx_Serial(a_tx_ser), .o_Tx_Done(a_tx_done)
  );

  // 7O2 instance, permanently looped back
  logic       b_tx_dv = 1'b0;
  logic [6:0] b_tx_byte = 7'h00;
  logic       b_rx_dv, b_pe, b_fe, b_tx_active, b_tx_ser, b_tx_done;
  logic [6:0] b_rx_byte;

  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(b_tx_ser),
    .o_Rx_DV(b_rx_dv), .o_Rx_Byte(b_rx_byte), .o_Rx_Parity_Err(b_pe), .o_Rx_Frame_Err(b_fe),
    .i_Tx_DV(b_tx_dv), .i_Tx_Byte(b_tx_byte),
    .o_Tx_Active(b_tx_active), .o_Tx_Serial(b_tx_ser), .o_Tx_Done(b_tx_done)
  );

  int a_dv_n = 0, b_dv_n = 0, a_done_n = 0;
  always @(negedge clk) begin
    if (a_rx_dv) a_dv_n++;
    if (b_rx_dv) b_dv_n++;
    if (a_tx_done) a_done_n++;
  end

  logic sel = 1'b0;
  logic m_done, m_ser;
  assign m_done = sel ? b_tx_done : a_tx_done;
  assign m_ser  = sel ? b_tx_ser : a_tx_ser;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request one TX frame, then record the mid-bit line values and the cycles until Done.
  task automatic tx_frame(input logic s, input logic [7:0] d, output int len, output logic [11:0] bits);
    sel  = s;
    bits = '1;
    if (s) begin b_tx_byte = d[6:0]; b_tx_dv = 1'b1; end
    else   begin a_tx_byte = d;      a_tx_dv = 1'b1; end
    @(negedge clk);
    a_tx_dv = 1'b0;
    b_tx_dv = 1'b0;
    len = 0;
    while (!m_done && len < 400) begin
      if (len % CPB == CPB / 2 && len < 12 * CPB) bits[len / CPB] = m_ser;
      @(negedge clk);
      len++;
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic pflip, input logic stop_v);
    a_rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a_rx_drv = d[i];
      repeat (CPB) @(negedge clk);
    end
    a_rx_drv = (^d) ^ pflip;
    repeat (CPB) @(negedge clk);
    a_rx_drv = stop_v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_dv(input logic s, input int n0);
    int t = 0;
    while ((s ? b_dv_n : a_dv_n) == n0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  int          n, nd, len, t;
  logic [11:0] bits;
  logic [10:0] lv;
  logic        s1;
  logic [6:0]  v7 [3] = '{7'h7F, 7'h00, 7'h2A};
  logic        p7 [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ser", 32'(a_tx_ser), 32'(1'b1));
    check("rst_tx_active", 32'(a_tx_active), 32'(1'b0));
    check("rst_tx_done", 32'(a_tx_done), 32'(1'b0));
    check("rst_rx_dv", 32'(a_rx_dv), 32'(1'b0));
    check("rst_rx_byte", 32'(a_rx_byte), 32'h0);
    check("rst_errs", 32'({a_pe, a_fe}), 32'h0);
    check("rst_b_tx_ser", 32'(b_tx_ser), 32'(1'b1));
    rst = 1'b0;
    @(negedge clk);

    // 8E1 loopback 0xA5: even parity bit 0, 88-cycle frame
    a_loop = 1'b1;
    n = a_dv_n;
    tx_frame(1'b0, 8'hA5, len, bits);
    check("a5_len", 32'(len), 32'd88);
    check("a5_done_inactive", 32'(a_tx_active), 32'(1'b0));
    check("a5_par_bit", 32'(bits[9]), 32'(1'b0));
    check("a5_wire", 32'(bits[10:0]), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
    wait_dv(1'b0, n);
    check("a5_dv_cnt", 32'(a_dv_n - n), 32'd1);
    check("a5_byte", 32'(a_rx_byte), 32'hA5);
    check("a5_errs", 32'({a_pe, a_fe}), 32'h0);
    a_loop = 1'b0;
    repeat (4) @(negedge clk);

    // parity error on 0x3C
    n = a_dv_n;
    rx_frame(8'h3C, 1'b1, 1'b1);
    wait_dv(1'b0, n);
    check("pe_dv_cnt", 32'(a_dv_n - n), 32'd1);
    check("pe_byte", 32'(a_rx_byte), 32'h3C);
    check("pe_flag", 32'(a_pe), 32'(1'b1));
    check("pe_fe", 32'(a_fe), 32'(1'b0));

    // 0x55 with low stop bit, then a break of three frame times
    n = a_dv_n;
    rx_frame(8'h55, 1'b0, 1'b0);
    a_rx_drv = 1'b0;
    repeat (3 * 88) @(negedge clk);
    a_rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("fe_dv_cnt", 32'(a_dv_n - n), 32'd1);
    check("fe_byte", 32'(a_rx_byte), 32'h55);
    check("fe_flag", 32'(a_fe), 32'(1'b1));
    check("fe_pe", 32'(a_pe), 32'(1'b0));
    n = a_dv_n;
    rx_frame(8'h12, 1'b0, 1'b1);
    wait_dv(1'b0, n);
    check("post_break_dv_cnt", 32'(a_dv_n - n), 32'd1);
    check("post_break_byte", 32'(a_rx_byte), 32'h12);
    check("post_break_errs", 32'({a_pe, a_fe}), 32'h0);

    // 2-cycle glitch, then a valid frame right after
    n = a_dv_n;
    a_rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    a_rx_drv = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_no_dv", 32'(a_dv_n - n), 32'd0);
    rx_frame(8'hC7, 1'b0, 1'b1);
    wait_dv(1'b0, n);
    check("glitch_next_dv_cnt", 32'(a_dv_n - n), 32'd1);
    check("glitch_next_byte", 32'(a_rx_byte), 32'hC7);

    // back-to-back TX with i_Tx_DV held
    a_loop = 1'b1;
    n = a_dv_n;
    a_tx_byte = 8'h01;
    a_tx_dv = 1'b1;
    @(negedge clk);
    a_tx_byte = 8'h02;
    t = 0;
    while (!a_tx_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("b2b_done1", 32'(a_tx_done), 32'(1'b1));
    check("b2b_gap_high", 32'(a_tx_ser), 32'(1'b1));
    bits = '1;
    s1 = 1'b1;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        s1 = a_tx_ser;
        a_tx_dv = 1'b0;
      end
      if (a_tx_done) break;
      if ((t - 1) % CPB == CPB / 2 && t - 1 < 12 * CPB) bits[(t - 1) / CPB] = a_tx_ser;
    end
    check("b2b_second_start_low", 32'(s1), 32'(1'b0));
    check("b2b_done_spacing", 32'(t), 32'd89);
    check("b2b_wire_02", 32'(bits[10:0]), 32'({1'b1, 1'b1, 8'h02, 1'b0}));
    repeat (20) @(negedge clk);
    check("b2b_rx_cnt", 32'(a_dv_n - n), 32'd2);
    check("b2b_rx_byte", 32'(a_rx_byte), 32'h02);
    a_loop = 1'b0;

    // 7O2 loopback
    for (int i = 0; i < 3; i++) begin
      n = b_dv_n;
      tx_frame(1'b1, {1'b0, v7[i]}, len, bits);
      check("o2_len", 32'(len), 32'd88);
      check("o2_wire", 32'(bits[10:0]), 32'({2'b11, p7[i], v7[i], 1'b0}));
      wait_dv(1'b1, n);
      check("o2_dv_cnt", 32'(b_dv_n - n), 32'd1);
      check("o2_byte", 32'(b_rx_byte), 32'(v7[i]));
      check("o2_errs", 32'({b_pe, b_fe}), 32'h0);
    end

    // reset during TX data bit 3 and RX data bit 5
    n  = a_dv_n;
    nd = a_done_n;
    lv = {1'b1, 1'b0, 8'hB4, 1'b0};
    for (int c = 0; c < 53; c++) begin
      a_rx_drv  = lv[c / CPB];
      a_tx_dv   = (c == 16);
      a_tx_byte = 8'hC3;
      @(negedge clk);
    end
    check("mid_active_before_rst", 32'(a_tx_active), 32'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx_ser", 32'(a_tx_ser), 32'(1'b1));
    check("mid_rst_tx_active", 32'(a_tx_active), 32'(1'b0));
    a_rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_dv", 32'(a_dv_n - n), 32'd0);
    check("mid_rst_no_done", 32'(a_done_n - nd), 32'd0);
    check("mid_rst_rx_byte", 32'(a_rx_byte), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    a_loop = 1'b1;
    tx_frame(1'b0, 8'h96, len, bits);
    check("after_rst_len", 32'(len), 32'd88);
    wait_dv(1'b0, n);
    check("after_rst_dv_cnt", 32'(a_dv_n - n), 32'd1);
    check("after_rst_byte", 32'(a_rx_byte), 32'h96);
    check("after_rst_errs", 32'({a_pe, a_fe}), 32'h0);
    check("after_rst_done_cnt", 32'(a_done_n - nd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: one TX and one RX engine on a shared clock, with configurable data width, parity mode and stop-bit count. It adds parity and framing error reporting, an input synchroniser with start-bit glitch rejection, and break-safe re-arming. It is the drop-in successor to the fixed 8N1 UART top for all new serial-port instances, and sits between the board pins and the byte-level command logic.

## Interface
- CLKS_PER_BIT, 87: clocks per bit period. Legal range is ≥ 4.
- DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame. Legal values are 1 and 2.
- i_Clock  in  1  system clock; every flop is rising-edge.
- i_Reset  in  1  asynchronous reset, active-high.
- i_Rx_Serial  in  1  RX line; asynchronous to i_Clock; idles high.
- o_Rx_DV  out  1  one-cycle pulse; a received frame is complete.
- o_Rx_Byte  out  DATA_BITS  received data, LSB = first bit on the wire; held until the next DV.
- o_Rx_Parity_Err  out  1  valid with o_Rx_DV; held until the next DV.
- o_Rx_Frame_Err  out  1  valid with o_Rx_DV; first stop bit sampled low; held until the next DV.
- i_Tx_DV  in  1  request to send i_Tx_Byte; sampled only when TX is idle.
- i_Tx_Byte  in  DATA_BITS  data to transmit.
- o_Tx_Active  out  1  high while a frame is on the wire.
- o_Tx_Serial  out  1  TX line.
- o_Tx_Done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- **Reset values:** o_Tx_Serial = 1, synchroniser flops = 1, every other output and register = 0, both FSMs in IDLE. Reset asserted mid-frame aborts the frame immediately; no DV or Done pulse is emitted.
- **Frame format:** start bit (0), then DATA_BITS data bits LSB first, then the parity bit if PARITY ≠ 0, then STOP_BITS stop bits (1).
- **Parity bit:** even = XOR of the data bits; odd = inverse of that XOR.
- **TX FSM:** IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
  - Each bit lasts exactly CLKS_PER_BIT clocks. STOP lasts STOP_BITS × CLKS_PER_BIT clocks.
  - i_Tx_Byte is latched when i_Tx_DV is sampled high in IDLE. i_Tx_DV is ignored at all other times.
- **RX synchroniser:** two-flop synchroniser; every RX decision uses the synchronised line.
- **RX FSM:** IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE, plus a WAIT_IDLE state.
  - IDLE: a low line moves to START.
  - START: at count (CLKS_PER_BIT−1)/2 the line is re-sampled. Still low: the counter clears and the FSM moves to DATA. High: glitch, return to IDLE with no output.
  - DATA, PARITY and STOP: one sample every CLKS_PER_BIT clocks, i.e. at mid-bit.
  - A received parity mismatch sets o_Rx_Parity_Err.
  - Only the first stop-bit sample sets o_Rx_Frame_Err; the second stop bit is sampled but not checked.
  - After the last stop-bit sample: outputs update, o_Rx_DV pulses, then the FSM goes to IDLE.
  - If o_Rx_Frame_Err = 1, the FSM goes to WAIT_IDLE instead of IDLE, and stays there until the synchronised line is high. A held break therefore yields exactly one DV.
- RX and TX are fully independent; simultaneous activity on both is legal.

## Timing
- **TX latency:** i_Tx_DV sampled high in IDLE at edge N → o_Tx_Serial = 0 and o_Tx_Active = 1 from edge N+1.
- **TX frame length:** F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT clocks.
- **o_Tx_Done:** high for the single cycle that starts at edge N+1+F. In that cycle o_Tx_Active = 0 and the FSM is in IDLE.
- **Back-to-back TX:** i_Tx_DV high in the Done cycle is accepted, so the next start bit begins at edge N+2+F with no idle gap beyond that one cycle (o_Tx_Serial stays 1 for that cycle).
- **RX latency:** 2 clocks of synchroniser delay to the FSM. o_Rx_DV pulses exactly one cycle, in the cycle after the last stop-bit sample edge.
- Error flags and o_Rx_Byte change only in the same cycle o_Rx_DV rises.

## Test plan
All scenarios use CLKS_PER_BIT = 8 unless stated otherwise.
- **Loopback, 8E1 (DATA_BITS = 8, PARITY = 2):** drive o_Tx_Serial into i_Rx_Serial and send 0xA5 → parity bit on the wire = 0, o_Tx_Done exactly 88 cycles after TX starts; o_Rx_DV with o_Rx_Byte = 0xA5 and both error flags = 0.
- **Parity and framing errors, 8E1:** inject 0x3C with the parity bit flipped → DV, byte = 0x3C, Parity_Err = 1, Frame_Err = 0. Next, inject 0x55 with the stop bit low, then hold the line low for 3 frame times → exactly one DV with Frame_Err = 1; a valid 0x12 sent afterwards is received cleanly.
- **Glitch rejection:** a 2-cycle low pulse on an idle line → no DV, and the FSM is back in IDLE; a valid frame immediately afterwards is received.
- **Back-to-back TX:** hold i_Tx_DV high, with 0x01 presented first and then 0x02 → o_Tx_Done pulses 89 cycles apart, o_Tx_Serial is high for exactly one cycle between the frames, and 0x02 is transmitted intact.
- **Alternate config, 7O2 (DATA_BITS = 7, PARITY = 1, STOP_BITS = 2):** loopback 0x7F, 0x00 and 0x2A → TX frame = 88 cycles; received bytes match, parity bits on the wire are 0, 1 and 0, no errors.
- **Reset mid-frame:** assert i_Reset during TX data bit 3 and RX data bit 5 → o_Tx_Serial = 1 and o_Tx_Active = 0 asynchronously, with no Done or DV pulse; after release, the next frame sent and received is correct.
